// File: rtl/icache_responder.sv
// icache_responder
//   Direct-mapped, read-only instruction cache sitting between the fetch stage
//   and the memory arbiter. It registers a fetch address and compares tags on
//   the next cycle. On a miss it refills the whole line one word at a time.
//
//   Optional feature: define ORION_ICACHE_PERF_EN to add the hit/miss
//   performance counters and their ports.
//
// Ports
//   clk_i, rst_ni     clock, synchronous active-low reset
//   imem_addr_i       fetch address (bits [1:0] ignored)
//   imem_valid_i      fetch request valid
//   imem_rdata_o      instruction word for the address sampled last cycle
//   imem_resp_o       imem_rdata_o valid (hit) this cycle
//   flush_i           invalidate all lines (one-cycle pulse)
//   mem_addr_o        refill word address, held until mem_resp_i
//   mem_valid_o       refill request
//   mem_rdata_i       refill data, valid with mem_resp_i
//   mem_resp_i        refill word returned this cycle
//   hit_cnt_o         saturating hit count   (ORION_ICACHE_PERF_EN)
//   miss_cnt_o        saturating miss count  (ORION_ICACHE_PERF_EN)
//
// state  | meaning
// -------+----------------------------------------------------------------
// LOOKUP | sample fetch requests, compare the previously sampled address
// REFILL | fetch LINE_WORDS words of the missing line from backing memory

module icache_responder #(
    // ADDRW/DATAW mirror the orion_types widths
    parameter int ADDRW      = 32,
    parameter int DATAW      = 32,
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [ADDRW-1:0] imem_addr_i,
    input  logic             imem_valid_i,
    output logic [DATAW-1:0] imem_rdata_o,
    output logic             imem_resp_o,
    input  logic             flush_i,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic             mem_valid_o,
    input  logic [DATAW-1:0] mem_rdata_i,
    input  logic             mem_resp_i
`ifdef ORION_ICACHE_PERF_EN
    ,
    output logic [31:0]      hit_cnt_o,
    output logic [31:0]      miss_cnt_o
`endif
);

    localparam int IDXW = $clog2(NUM_LINES);
    localparam int OFFW = $clog2(LINE_WORDS);
    localparam int TAGW = ADDRW - IDXW - OFFW - 2;

    typedef enum logic {LOOKUP, REFILL} state_t;

    state_t                   state_q, state_d;
    logic                     req_vld_q;
    logic [ADDRW-1:2]         req_addr_q;
    logic [TAGW-1:0]          line_tag_q;
    logic [IDXW-1:0]          line_idx_q;
    logic [OFFW-1:0]          w_q;
    logic                     gap_q;
    logic                     flush_pend_q;
    logic [NUM_LINES-1:0]     valid_q;

    logic [TAGW-1:0]          tag_mem  [NUM_LINES];
    logic [DATAW-1:0]         data_mem [NUM_LINES*LINE_WORDS];

    logic [TAGW-1:0]          req_tag;
    logic [IDXW-1:0]          req_idx;
    logic [OFFW-1:0]          req_off;
    logic                     tag_match;
    logic                     hit;
    logic                     miss;
    logic                     mem_fire;
    logic                     last;
    logic                     unused_addr_bits;

    // Word-aligned fetches: the byte offset carries no information.
    assign unused_addr_bits = ^imem_addr_i[1:0];

    assign req_tag = req_addr_q[ADDRW-1 -: TAGW];
    assign req_idx = req_addr_q[OFFW+2 +: IDXW];
    assign req_off = req_addr_q[2 +: OFFW];

    assign tag_match = req_vld_q && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // A flush in the compare cycle suppresses both the hit and the refill.
    assign hit  = (state_q == LOOKUP) && tag_match && !flush_i;
    assign miss = (state_q == LOOKUP) && req_vld_q && !tag_match && !flush_i;

    // gap_q drops the request for one cycle after every returned word.
    assign mem_valid_o = (state_q == REFILL) && !gap_q;
    assign mem_addr_o  = {line_tag_q, line_idx_q, w_q, 2'b00};
    assign mem_fire    = mem_valid_o && mem_resp_i;
    assign last        = mem_fire && (w_q == OFFW'(LINE_WORDS - 1));

    assign imem_resp_o  = hit;
    assign imem_rdata_o = hit ? data_mem[{req_idx, req_off}] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOOKUP:  if (miss) state_d = REFILL;
            REFILL:  if (last) state_d = LOOKUP;
            default: state_d = LOOKUP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= LOOKUP;
            req_vld_q    <= 1'b0;
            req_addr_q   <= '0;
            line_tag_q   <= '0;
            line_idx_q   <= '0;
            w_q          <= '0;
            gap_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q   <= state_d;
            // Requests are not queued: anything presented during a miss or
            // a refill is dropped and must be re-presented.
            req_vld_q <= (state_q == LOOKUP) && !miss && imem_valid_i;
            if ((state_q == LOOKUP) && !miss && imem_valid_i) begin
                req_addr_q <= imem_addr_i[ADDRW-1:2];
            end

            if (miss) begin
                line_tag_q   <= req_tag;
                line_idx_q   <= req_idx;
                w_q          <= '0;
                gap_q        <= 1'b0;
                flush_pend_q <= 1'b0;
            end

            if (state_q == REFILL) begin
                gap_q        <= mem_fire;
                flush_pend_q <= flush_pend_q | flush_i;
                if (mem_fire) begin
                    w_q <= w_q + OFFW'(1);
                end
            end

            // A flush seen at any point of a refill leaves the new line invalid.
            if ((state_q == LOOKUP) && flush_i) begin
                valid_q <= '0;
            end else if (last) begin
                if (flush_pend_q || flush_i) begin
                    valid_q <= '0;
                end else begin
                    valid_q[line_idx_q] <= 1'b1;
                end
            end
        end
    end

    // Storage arrays need no reset; validity lives in valid_q.
    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_fire) begin
            data_mem[{line_idx_q, w_q}] <= mem_rdata_i;
        end
        if (rst_ni && last) begin
            tag_mem[line_idx_q] <= line_tag_q;
        end
    end

`ifdef ORION_ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] imem_addr_i;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_o;
    logic        imem_resp_o;
    logic        flush_i;
    logic [31:0] mem_addr_o;
    logic        mem_valid_o;
    logic [31:0] mem_rdata_i;
    logic        mem_resp_i;
`ifdef ORION_ICACHE_PERF_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    icache_responder dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_addr_i  (imem_addr_i),
        .imem_valid_i (imem_valid_i),
        .imem_rdata_o (imem_rdata_o),
        .imem_resp_o  (imem_resp_o),
        .flush_i      (flush_i),
        .mem_addr_o   (mem_addr_o),
        .mem_valid_o  (mem_valid_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_resp_i   (mem_resp_i)
`ifdef ORION_ICACHE_PERF_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic        resp;
        logic [31:0] data;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        int          lat;
    } vec_t;

    localparam int NV = 15;

    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          mem_lat = 1;
    bit          mem_en  = 1'b1;
    bit          stray   = 1'b0;
    exp_t        resp_q[$];
    logic [31:0] mem_q[$];
    vec_t        vecs[NV];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h3C5A_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            cyc = cyc + 1;
        end
    end

    // Backing memory: answers mem_lat cycles after the request first appears.
    initial begin
        int lat_cnt;
        lat_cnt     = 0;
        mem_resp_i  = 1'b0;
        mem_rdata_i = '0;
        forever begin
            cycle();
            if (stray) begin
                mem_resp_i  = 1'b1;
                mem_rdata_i = 32'hDEAD_BEEF;
            end else if (mem_en && mem_valid_o === 1'b1) begin
                if (lat_cnt == mem_lat) begin
                    mem_resp_i  = 1'b1;
                    mem_rdata_i = mem_word(mem_addr_o);
                    lat_cnt     = 0;
                end else begin
                    mem_resp_i = 1'b0;
                    lat_cnt++;
                end
            end else begin
                mem_resp_i = 1'b0;
                lat_cnt    = 0;
            end
        end
    end

    // Scoreboard consumers: fetch responses and refill requests.
    initial begin
        exp_t e;
        bit   got;
        forever begin
            @(negedge clk_i);
            got = 1'b0;
            while (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                e   = resp_q.pop_front();
                got = 1'b1;
                check({e.name, "_resp"}, 32'(imem_resp_o), 32'(e.resp));
                if (e.resp) check({e.name, "_rdata"}, imem_rdata_o, e.data);
            end
            if (!got && imem_resp_o !== 1'b0) check("unexpected_resp", 32'(imem_resp_o), 32'd0);
            if (mem_valid_o === 1'b1 && mem_resp_i === 1'b1) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req: got addr %h expected no request", mem_addr_o);
                end else begin
                    check("mem_addr", mem_addr_o, mem_q.pop_front());
                end
            end
        end
    end

    task automatic refill_wait(input int flush_at, input string name);
        int n  = 0;
        bit fl = 1'b0;
        while (mem_q.size() > 0 && n < 300) begin
            if (flush_at >= 0 && !fl && mem_q.size() == flush_at) begin
                flush_i = 1'b1;
                fl      = 1'b1;
            end else begin
                flush_i = 1'b0;
            end
            // Junk requests during the refill must be ignored.
            imem_valid_i = 1'b1;
            imem_addr_i  = $urandom;
            cycle();
            n++;
        end
        flush_i      = 1'b0;
        imem_valid_i = 1'b0;
        check({name, "_refill_done"}, 32'(mem_q.size()), 32'd0);
        mem_q.delete();
    endtask

    task automatic do_access(input logic [31:0] addr, input bit exp_hit, input int lat,
                             input int flush_at, input string name);
        logic [31:0] base;
        mem_lat      = lat;
        imem_addr_i  = addr;
        imem_valid_i = 1'b1;
        resp_q.push_back('{cyc + 1, exp_hit, mem_word(addr), name});
        cycle();
        imem_valid_i = 1'b0;
        if (!exp_hit) begin
            base = addr & 32'hFFFF_FFF0;
            for (int k = 0; k < 4; k++) mem_q.push_back(base + 32'(4 * k));
            refill_wait(flush_at, name);
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{32'h8000_0000, 1'b0, 1};
        vecs[1]  = '{32'h8000_0000, 1'b1, 1};
        vecs[2]  = '{32'h8000_0004, 1'b1, 1};
        vecs[3]  = '{32'h8000_0008, 1'b1, 1};
        vecs[4]  = '{32'h8000_000C, 1'b1, 1};
        vecs[5]  = '{32'h8000_0400, 1'b0, 0};
        vecs[6]  = '{32'h8000_0400, 1'b1, 0};
        vecs[7]  = '{32'h8000_040C, 1'b1, 0};
        vecs[8]  = '{32'h8000_0000, 1'b0, 2};
        vecs[9]  = '{32'h8000_0004, 1'b1, 2};
        vecs[10] = '{32'h8000_0012, 1'b0, 3};
        vecs[11] = '{32'h8000_001C, 1'b1, 3};
        vecs[12] = '{32'h8000_0016, 1'b1, 3};
        vecs[13] = '{32'h0000_0000, 1'b0, 1};
        vecs[14] = '{32'h0000_0008, 1'b1, 1};

        rst_ni       = 1'b0;
        imem_valid_i = 1'b0;
        imem_addr_i  = '0;
        flush_i      = 1'b0;
        repeat (3) cycle();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_resp", 32'(imem_resp_o), 32'd0);
        check("rst_rdata", imem_rdata_o, 32'd0);
        check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
`ifdef ORION_ICACHE_PERF_EN
        check("rst_hit_cnt", hit_cnt_o, 32'd0);
        check("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
        cycle();

        // Cold miss, line hits, conflict, re-miss, low address bits ignored.
        for (int i = 0; i < NV; i++) begin
            do_access(vecs[i].addr, vecs[i].hit, vecs[i].lat, -1, $sformatf("vec%0d", i));
`ifdef ORION_ICACHE_PERF_EN
            if (i == 4) begin
                cycle();
                check("perf_hit_cnt", hit_cnt_o, 32'd4);
                check("perf_miss_cnt", miss_cnt_o, 32'd1);
            end
`endif
        end

        // Flush while a hit is being compared.
        do_access(32'h8000_0020, 1'b0, 1, -1, "a_fill");
        do_access(32'h8000_0020, 1'b1, 1, -1, "a_warm");
        imem_addr_i  = 32'h8000_0020;
        imem_valid_i = 1'b1;
        resp_q.push_back('{cyc + 1, 1'b0, 32'd0, "a_flush_cmp"});
        cycle();
        imem_valid_i = 1'b0;
        flush_i      = 1'b1;
        cycle();
        flush_i = 1'b0;
        @(negedge clk_i);
        check("a_no_refill", 32'(mem_valid_o), 32'd0);
        cycle();
        do_access(32'h8000_0020, 1'b0, 1, -1, "a_after_flush");
        do_access(32'h8000_0020, 1'b1, 1, -1, "a_rehit");
        do_access(32'h0000_0000, 1'b0, 0, -1, "a_other_flushed");
        do_access(32'h0000_0004, 1'b1, 0, -1, "a_other_rehit");

        // Flush together with a miss: no refill.
        imem_addr_i  = 32'h8000_0040;
        imem_valid_i = 1'b1;
        resp_q.push_back('{cyc + 1, 1'b0, 32'd0, "c_flush_miss"});
        cycle();
        imem_valid_i = 1'b0;
        flush_i      = 1'b1;
        cycle();
        flush_i = 1'b0;
        @(negedge clk_i);
        check("c_no_refill", 32'(mem_valid_o), 32'd0);
        cycle();
        @(negedge clk_i);
        check("c_no_refill2", 32'(mem_valid_o), 32'd0);
        cycle();
        do_access(32'h8000_0040, 1'b0, 1, -1, "c_miss");
        do_access(32'h8000_0048, 1'b1, 1, -1, "c_hit");

        // Flush in the middle of a refill: line completes but is not valid.
        do_access(32'h8000_0030, 1'b0, 1, 2, "b_fill_flushed");
        do_access(32'h8000_0030, 1'b0, 1, -1, "b_refetch");
        do_access(32'h8000_0034, 1'b1, 1, -1, "b_hit");
        do_access(32'h8000_0040, 1'b0, 2, -1, "b_all_flushed");
        do_access(32'h8000_0040, 1'b1, 2, -1, "b_all_rehit");

        // Reset while word 2 of a refill is outstanding.
        mem_lat      = 3;
        imem_addr_i  = 32'h8000_0050;
        imem_valid_i = 1'b1;
        resp_q.push_back('{cyc + 1, 1'b0, 32'd0, "d_miss"});
        cycle();
        imem_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) mem_q.push_back(32'h8000_0050 + 32'(4 * k));
        n = 0;
        while (!(mem_q.size() == 2 && mem_valid_o === 1'b1) && n < 300) begin
            cycle();
            n++;
        end
        check("d_reach_w2", 32'(n < 300), 32'd1);
        mem_en = 1'b0;
        rst_ni = 1'b0;
        cycle();
        rst_ni = 1'b1;
        stray  = 1'b1;
        @(negedge clk_i);
        check("d_mem_valid", 32'(mem_valid_o), 32'd0);
        check("d_mem_addr", mem_addr_o, 32'd0);
        check("d_resp", 32'(imem_resp_o), 32'd0);
        cycle();
        @(negedge clk_i);
        check("d_stray_ignored", 32'(mem_valid_o), 32'd0);
`ifdef ORION_ICACHE_PERF_EN
        check("d_hit_cnt", hit_cnt_o, 32'd0);
        check("d_miss_cnt", miss_cnt_o, 32'd0);
`endif
        cycle();
        stray  = 1'b0;
        mem_en = 1'b1;
        mem_q.delete();
        do_access(32'h8000_0050, 1'b0, 1, -1, "d_after_rst");
        do_access(32'h8000_005C, 1'b1, 1, -1, "d_hit");
        do_access(32'h0000_0000, 1'b0, 1, -1, "d_cold_again");
        do_access(32'h0000_0000, 1'b1, 1, -1, "d_cold_rehit");

        repeat (3) cycle();
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
